// File: rtl/gary_bus_pkg.sv
// Shared types for the gary bus controller: cycle states and per-region decode configuration.
package gary_bus_pkg;

    localparam int DEC_W_MAX  = 24;
    localparam int WAIT_W_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_BERR   = 3'd4,
        ST_PASS   = 3'd5
    } busState_e;

    typedef struct packed {
        logic [DEC_W_MAX-1:0]  base;
        logic [DEC_W_MAX-1:0]  mask;
        logic [WAIT_W_MAX-1:0] waitStates;
        logic                  ext;
        logic                  vpa;
        logic                  ro;
    } region_cfg_t;

    // Fields arrive as slices of the flat configuration ports, zero-extended to the max widths.
    function automatic region_cfg_t unpackRegion(
        input logic [DEC_W_MAX-1:0]  base,
        input logic [DEC_W_MAX-1:0]  mask,
        input logic [WAIT_W_MAX-1:0] waitStates,
        input logic                  ext,
        input logic                  vpa,
        input logic                  ro
    );
        region_cfg_t cfg;
        cfg.base       = base;
        cfg.mask       = mask;
        cfg.waitStates = waitStates;
        cfg.ext        = ext;
        cfg.vpa        = vpa;
        cfg.ro         = ro;
        return cfg;
    endfunction

endpackage

// File: rtl/gary_region_decode.sv
// Combinational priority matcher: lowest-index region whose masked base matches the address wins.
module gary_region_decode
    import gary_bus_pkg::*;
#(
    parameter int NUM_REGIONS = 8,
    parameter int DEC_W       = 7,
    parameter int IDX_W       = 3
) (
    input  logic [DEC_W-1:0]       addr,
    input  logic                   rw,
    input  region_cfg_t            cfg [NUM_REGIONS],
    output logic                   hit,
    output logic [IDX_W-1:0]       idx,
    output logic [NUM_REGIONS-1:0] oneHot
);

    logic [NUM_REGIONS-1:0] match_s;
    logic                   taken_s;

    // Per-region match followed by a lowest-index-first priority chain
    always_comb begin
        match_s = {NUM_REGIONS{1'b0}};
        oneHot  = {NUM_REGIONS{1'b0}};
        idx     = {IDX_W{1'b0}};
        taken_s = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match_s[i] = ((((addr ^ cfg[i].base[DEC_W-1:0]) & cfg[i].mask[DEC_W-1:0])
                          == {DEC_W{1'b0}}) && (rw || !cfg[i].ro));
            oneHot[i]  = match_s[i] & ~taken_s;
            taken_s    = taken_s | match_s[i];
            idx        = idx | ({IDX_W{oneHot[i]}} & IDX_W'(i));
        end
        hit = taken_s;
    end

endmodule

// File: rtl/gary_bus_ctrl.sv
// Chip-bus address decoder and cycle terminator: region select, wait states, nDTACK/nVPA, bus-error timeout.
// Optional feature macro: GARY_BUS_TIMEOUT_EN enables the unclaimed-cycle timeout and nBERR.
module gary_bus_ctrl
    import gary_bus_pkg::*;
#(
    parameter int NUM_REGIONS = 8,
    parameter int DEC_W       = 7,
    parameter int WAIT_W      = 4,
    parameter int TO_CYCLES   = 256
) (
    input  logic                          clk,
    input  logic                          nRESET,
    input  logic                          nAS,
    input  logic                          RW,
    input  logic                          nOVR,
    input  logic                          XRDY,
    input  logic [DEC_W-1:0]              A,
    input  logic [NUM_REGIONS*DEC_W-1:0]  region_base,
    input  logic [NUM_REGIONS*DEC_W-1:0]  region_mask,
    input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
    input  logic [NUM_REGIONS-1:0]        region_ext,
    input  logic [NUM_REGIONS-1:0]        region_vpa,
    input  logic [NUM_REGIONS-1:0]        region_ro,
    output logic [NUM_REGIONS-1:0]        nSEL,
    output logic                          nDTACK,
    output logic                          nVPA,
    output logic                          nBERR,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    region_cfg_t            cfg_s [NUM_REGIONS];
    busState_e              state_r;
    busState_e              nextState_s;
    logic [DEC_W-1:0]       aLat_r;
    logic                   rwLat_r;
    logic                   hit_r;
    logic [IDX_W-1:0]       selIdx_r;
    logic [WAIT_W-1:0]      waitCnt_r;
    logic                   decHit_s;
    logic [IDX_W-1:0]       decIdx_s;
    logic [NUM_REGIONS-1:0] decOh_s;
    logic                   waitDone_s;
    logic                   timeout_s;
    logic [NUM_REGIONS-1:0] nSelNext_s;
    logic                   nDtackNext_s;
    logic                   nVpaNext_s;
    logic                   nBerrNext_s;
    logic                   unusedCfg_s;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_cfg
        assign cfg_s[i] = unpackRegion(DEC_W_MAX'(region_base[i*DEC_W +: DEC_W]),
                                       DEC_W_MAX'(region_mask[i*DEC_W +: DEC_W]),
                                       WAIT_W_MAX'(region_wait[i*WAIT_W +: WAIT_W]),
                                       region_ext[i], region_vpa[i], region_ro[i]);
    end

    // Upper bits of the max-width config fields are zero-fill only
    always_comb begin
        unusedCfg_s = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            unusedCfg_s = unusedCfg_s ^ (^cfg_s[i]);
        end
    end

    gary_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .DEC_W       (DEC_W),
        .IDX_W       (IDX_W)
    ) u_decode (
        .addr   (aLat_r),
        .rw     (rwLat_r),
        .cfg    (cfg_s),
        .hit    (decHit_s),
        .idx    (decIdx_s),
        .oneHot (decOh_s)
    );

    assign waitDone_s = hit_r && (waitCnt_r == {WAIT_W{1'b0}}) && (!cfg_s[selIdx_r].ext || XRDY);

`ifdef GARY_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES);
    logic [TO_W-1:0] toCnt_r;

    // Timeout counter: cleared on leaving DECODE, counts every edge spent in WAIT
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            toCnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_DECODE) begin
            toCnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            toCnt_r <= toCnt_r + TO_W'(1'b1);
        end else begin
            toCnt_r <= toCnt_r;
        end
    end

    assign timeout_s = (toCnt_r == TO_W'(TO_CYCLES - 1));
`else
    localparam int unusedToCycles = TO_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; nAS going high aborts or terminates any owned cycle
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE:   nextState_s = nAS ? ST_IDLE : (nOVR ? ST_DECODE : ST_PASS);
            ST_DECODE: nextState_s = nAS ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (nAS) begin
                    nextState_s = ST_IDLE;
                end else if (waitDone_s) begin
                    nextState_s = ST_ACK;
                end else if (timeout_s) begin
                    nextState_s = ST_BERR;
                end else begin
                    nextState_s = ST_WAIT;
                end
            end
            ST_ACK:    nextState_s = nAS ? ST_IDLE : ST_ACK;
            ST_BERR:   nextState_s = nAS ? ST_IDLE : ST_BERR;
            ST_PASS:   nextState_s = nAS ? ST_IDLE : ST_PASS;
            default:   nextState_s = ST_IDLE;
        endcase
    end

    // Address latch, decode result capture and wait-state down-counter
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            aLat_r    <= {DEC_W{1'b0}};
            rwLat_r   <= 1'b0;
            hit_r     <= 1'b0;
            selIdx_r  <= {IDX_W{1'b0}};
            waitCnt_r <= {WAIT_W{1'b0}};
        end else begin
            if (state_r == ST_IDLE && !nAS) begin
                aLat_r  <= A;
                rwLat_r <= RW;
            end else begin
                aLat_r  <= aLat_r;
                rwLat_r <= rwLat_r;
            end
            if (state_r == ST_DECODE) begin
                hit_r     <= decHit_s;
                selIdx_r  <= decIdx_s;
                waitCnt_r <= decHit_s ? cfg_s[decIdx_s].waitStates[WAIT_W-1:0] : waitCnt_r;
            end else if (state_r == ST_WAIT && hit_r && waitCnt_r != {WAIT_W{1'b0}}) begin
                waitCnt_r <= waitCnt_r - WAIT_W'(1'b1);
            end else begin
                waitCnt_r <= waitCnt_r;
            end
        end
    end

    // Output values for the state being entered, so every output changes on the same edge as the state
    always_comb begin
        nSelNext_s   = {NUM_REGIONS{1'b1}};
        nDtackNext_s = 1'b1;
        nVpaNext_s   = 1'b1;
        nBerrNext_s  = 1'b1;
        case (nextState_s)
            ST_WAIT: nSelNext_s = (state_r == ST_DECODE) ? ~decOh_s : nSEL;
            ST_ACK: begin
                nSelNext_s   = nSEL;
                nDtackNext_s = cfg_s[selIdx_r].vpa;
                nVpaNext_s   = ~cfg_s[selIdx_r].vpa;
            end
            ST_BERR: begin
                nSelNext_s = nSEL;
`ifdef GARY_BUS_TIMEOUT_EN
                nBerrNext_s = 1'b0;
`else
                nBerrNext_s = 1'b1;
`endif
            end
            default: nSelNext_s = {NUM_REGIONS{1'b1}};
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            nSEL   <= {NUM_REGIONS{1'b1}};
            nDTACK <= 1'b1;
            nVPA   <= 1'b1;
            nBERR  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            nSEL   <= nSelNext_s;
            nDTACK <= nDtackNext_s;
            nVPA   <= nVpaNext_s;
            nBERR  <= nBerrNext_s;
            busy   <= (nextState_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gary_bus_ctrl.sv
// Directed bench for gary_bus_ctrl: vector table of decode cycles plus hand-written corner sequences.
module tb_gary_bus_ctrl;

    localparam int NR = 8;
    localparam int DW = 7;
    localparam int WW = 4;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] a;
        logic          rw;
        bit            hit;
        int            idx;
        int            waits;
        bit            vpa;
    } vec_t;

    logic              clk = 1'b0;
    logic              nRESET;
    logic              nAS;
    logic              RW;
    logic              nOVR;
    logic              XRDY;
    logic [DW-1:0]     A;
    logic [NR*DW-1:0]  region_base;
    logic [NR*DW-1:0]  region_mask;
    logic [NR*WW-1:0]  region_wait;
    logic [NR-1:0]     region_ext;
    logic [NR-1:0]     region_vpa;
    logic [NR-1:0]     region_ro;
    logic [NR-1:0]     nSEL;
    logic              nDTACK;
    logic              nVPA;
    logic              nBERR;
    logic              busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    gary_bus_ctrl #(
        .NUM_REGIONS (NR),
        .DEC_W       (DW),
        .WAIT_W      (WW),
        .TO_CYCLES   (TO)
    ) dut (
        .clk         (clk),
        .nRESET      (nRESET),
        .nAS         (nAS),
        .RW          (RW),
        .nOVR        (nOVR),
        .XRDY        (XRDY),
        .A           (A),
        .region_base (region_base),
        .region_mask (region_mask),
        .region_wait (region_wait),
        .region_ext  (region_ext),
        .region_vpa  (region_vpa),
        .region_ro   (region_ro),
        .nSEL        (nSEL),
        .nDTACK      (nDTACK),
        .nVPA        (nVPA),
        .nBERR       (nBERR),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRegion(input int i, input logic [DW-1:0] base, input logic [DW-1:0] mask,
                             input logic [WW-1:0] w, input logic ext, input logic vpa, input logic ro);
        region_base[i*DW +: DW] = base;
        region_mask[i*DW +: DW] = mask;
        region_wait[i*WW +: WW] = w;
        region_ext[i] = ext;
        region_vpa[i] = vpa;
        region_ro[i]  = ro;
    endtask

    task automatic check(input string name, input logic [NR-1:0] eSel, input logic eDt,
                         input logic eVpa, input logic eBerr, input logic eBusy);
        logic [NR+3:0] act;
        logic [NR+3:0] exp;
        act = {nSEL, nDTACK, nVPA, nBERR, busy};
        exp = {eSel, eDt, eVpa, eBerr, eBusy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got nSEL=%b nDTACK=%b nVPA=%b nBERR=%b busy=%b, want nSEL=%b nDTACK=%b nVPA=%b nBERR=%b busy=%b",
                     name, nSEL, nDTACK, nVPA, nBERR, busy, eSel, eDt, eVpa, eBerr, eBusy);
        end
    endtask

    function automatic logic [NR-1:0] selOf(input int idx);
        logic [NR-1:0] one;
        one = {{(NR-1){1'b0}}, 1'b1};
        return ~(one << idx);
    endfunction

    // One complete cycle from the table: edge 0 samples nAS=0, then release and check idle.
    task automatic runEntry(input int id, input vec_t v);
        int  last;
        bit  ack;
        logic [NR-1:0] eSel;
        last = v.hit ? (3 + v.waits) : 6;
        A = v.a;
        RW = v.rw;
        nAS = 1'b0;
        for (int k = 0; k <= last; k++) begin
            tick();
            ack  = v.hit && (k >= 2 + v.waits);
            eSel = (v.hit && k >= 1) ? selOf(v.idx) : {NR{1'b1}};
            check($sformatf("vec%0d edge%0d", id, k), eSel, !(ack && !v.vpa), !(ack && v.vpa), 1'b1, 1'b1);
        end
        nAS = 1'b1;
        tick();
        check($sformatf("vec%0d release", id), {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        nRESET = 1'b0;
        nAS    = 1'b1;
        RW     = 1'b1;
        nOVR   = 1'b1;
        XRDY   = 1'b0;
        A      = 7'h00;
        region_base = '0;
        region_mask = '0;
        region_wait = '0;
        region_ext  = '0;
        region_vpa  = '0;
        region_ro   = '0;
        setRegion(0, 7'h10, 7'h7F, 4'd0, 1'b0, 1'b0, 1'b0);
        setRegion(1, 7'h20, 7'h7F, 4'd0, 1'b0, 1'b1, 1'b0);
        setRegion(2, 7'h50, 7'h7E, 4'd3, 1'b0, 1'b0, 1'b0);
        setRegion(3, 7'h10, 7'h70, 4'd1, 1'b0, 1'b0, 1'b0);
        setRegion(4, 7'h30, 7'h7F, 4'd0, 1'b0, 1'b0, 1'b1);
        setRegion(5, 7'h40, 7'h7F, 4'd1, 1'b1, 1'b0, 1'b0);
        setRegion(6, 7'h60, 7'h7F, 4'd5, 1'b0, 1'b0, 1'b0);
        setRegion(7, 7'h7F, 7'h7F, 4'd2, 1'b0, 1'b0, 1'b0);

        vecs[0] = '{7'h51, 1'b1, 1'b1, 2, 3, 1'b0};
        vecs[1] = '{7'h20, 1'b1, 1'b1, 1, 0, 1'b1};
        vecs[2] = '{7'h10, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[3] = '{7'h1A, 1'b0, 1'b1, 3, 1, 1'b0};
        vecs[4] = '{7'h30, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{7'h30, 1'b1, 1'b1, 4, 0, 1'b0};
        vecs[6] = '{7'h50, 1'b0, 1'b1, 2, 3, 1'b0};
        vecs[7] = '{7'h60, 1'b1, 1'b1, 6, 5, 1'b0};

        tick();
        tick();
        check("reset values", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);
        nRESET = 1'b1;
        tick();
        check("idle after reset", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            runEntry(i, vecs[i]);
        end

        // Abort in WAIT: nAS high before the wait states expire
        A = 7'h51; RW = 1'b1; nAS = 1'b0;
        tick();
        tick();
        check("abort sel edge1", selOf(2), 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        nAS = 1'b1;
        tick();
        check("abort release", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);

        // Ext region, wait 1, XRDY held low until edge 9
        A = 7'h40; RW = 1'b1; XRDY = 1'b0; nAS = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            check($sformatf("ext edge%0d", k), (k >= 1) ? selOf(5) : {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        XRDY = 1'b1;
        tick();
        check("ext edge9", selOf(5), 1'b0, 1'b1, 1'b1, 1'b1);
        nAS = 1'b1;
        tick();
        check("ext release", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);
        XRDY = 1'b0;

        // Override: block claims nothing but stays busy
        A = 7'h51; nOVR = 1'b0; nAS = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            tick();
            check($sformatf("ovr edge%0d", k), {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        nOVR = 1'b1;
        nAS = 1'b1;
        tick();
        check("ovr release", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);

        // Unclaimed cycle: timeout at edge 1+TO when enabled
        A = 7'h05; RW = 1'b1; nAS = 1'b0;
        for (int k = 0; k <= TO + 3; k++) begin
            tick();
`ifdef GARY_BUS_TIMEOUT_EN
            check($sformatf("miss edge%0d", k), {NR{1'b1}}, 1'b1, 1'b1, (k >= TO + 1) ? 1'b0 : 1'b1, 1'b1);
`else
            check($sformatf("miss edge%0d", k), {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
        end
        nAS = 1'b1;
        tick();
        check("miss release", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset during a wait-5 cycle, then a normal cycle
        A = 7'h60; RW = 1'b1; nAS = 1'b0;
        tick();
        tick();
        tick();
        check("pre-reset sel", selOf(6), 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        nRESET = 1'b0;
        #1;
        check("async reset", {NR{1'b1}}, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nAS = 1'b1;
        nRESET = 1'b1;
        tick();
        runEntry(100, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
